// File: rtl/tlb_assoc.sv
// Fully-associative MIPS32-style TLB: ASID/global matching, registered lookup,
// Random/Wired replacement and CP0 management ops (TLBWI, TLBWR, TLBR, TLBP).
module tlb_assoc #(
  parameter int ENTRIES = 16,
  parameter int ASID_W = 8,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [31:0]      req_vaddr,
  input  logic             req_write,
  output logic             rsp_valid,
  output logic [31:0]      rsp_paddr,
  output logic [1:0]       rsp_exc,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [IDX_W-1:0] op_index,
  input  logic [IDX_W-1:0] wired,
  input  logic [31:0]      entry_hi,
  input  logic [31:0]      entry_lo0,
  input  logic [31:0]      entry_lo1,
  output logic             op_done,
  output logic [31:0]      rd_hi,
  output logic [31:0]      rd_lo0,
  output logic [31:0]      rd_lo1,
  output logic [31:0]      probe_index,
  output logic [IDX_W-1:0] random
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [1:0] OP_TLBWI = 2'd0;
  localparam logic [1:0] OP_TLBWR = 2'd1;
  localparam logic [1:0] OP_TLBR  = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;
  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_REFILL = 2'd1;
  localparam logic [1:0] EXC_INVALID = 2'd2;
  localparam logic [1:0] EXC_MOD = 2'd3;

  logic [ENTRIES-1:0] present_r, g_r, d0_r, v0_r, d1_r, v1_r;
  logic [18:0]        vpn2_r [ENTRIES];
  logic [ASID_W-1:0]  asid_r [ENTRIES];
  logic [19:0]        pfn0_r [ENTRIES];
  logic [19:0]        pfn1_r [ENTRIES];

  logic [ENTRIES-1:0] lk_match_s, pb_match_s;
  logic [IDX_W:0]     lk_sel_s, pb_sel_s;
  logic [IDX_W-1:0]   lk_idx_s, wr_idx_s, random_nxt_s;
  logic [19:0]        sel_pfn_s;
  logic               sel_v_s, sel_d_s, wr_en_s;
  logic [31:0]        lk_paddr_s, probe_s;
  logic [1:0]         lk_exc_s;
  logic               unused_s;

  assign unused_s = ^{entry_hi[12:ASID_W], entry_lo0[31:26], entry_lo0[5:3],
                      entry_lo1[31:26], entry_lo1[5:3]};

  // Priority encoder: {hit, index} of the lowest-numbered set bit.
  function automatic logic [IDX_W:0] first_hit(input logic [ENTRIES-1:0] m);
    logic [IDX_W:0] r;
    r = {(IDX_W+1){1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  // Per-entry match for the lookup address and for the TLBP probe key.
  always_comb begin
    lk_match_s = {ENTRIES{1'b0}};
    pb_match_s = {ENTRIES{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match_s[i] = present_r[i] && (vpn2_r[i] == req_vaddr[31:13]) &&
                      (g_r[i] || (asid_r[i] == entry_hi[ASID_W-1:0]));
      pb_match_s[i] = present_r[i] && (vpn2_r[i] == entry_hi[31:13]) &&
                      (g_r[i] || (asid_r[i] == entry_hi[ASID_W-1:0]));
    end
  end

  // Lookup translation and exception classification.
  always_comb begin
    lk_sel_s  = first_hit(lk_match_s);
    lk_idx_s  = lk_sel_s[IDX_W-1:0];
    sel_pfn_s = req_vaddr[12] ? pfn1_r[lk_idx_s] : pfn0_r[lk_idx_s];
    sel_v_s   = req_vaddr[12] ? v1_r[lk_idx_s] : v0_r[lk_idx_s];
    sel_d_s   = req_vaddr[12] ? d1_r[lk_idx_s] : d0_r[lk_idx_s];
    if (req_vaddr[31:30] == 2'b10) begin
      lk_paddr_s = req_vaddr & 32'h1FFF_FFFF;
      lk_exc_s   = EXC_NONE;
    end else if (!lk_sel_s[IDX_W]) begin
      lk_paddr_s = 32'd0;
      lk_exc_s   = EXC_REFILL;
    end else if (!sel_v_s) begin
      lk_paddr_s = 32'd0;
      lk_exc_s   = EXC_INVALID;
    end else if (req_write && !sel_d_s) begin
      lk_paddr_s = 32'd0;
      lk_exc_s   = EXC_MOD;
    end else begin
      lk_paddr_s = {sel_pfn_s, req_vaddr[11:0]};
      lk_exc_s   = EXC_NONE;
    end
  end

  // Probe result, write target and next Random value.
  always_comb begin
    pb_sel_s = first_hit(pb_match_s);
    if (pb_sel_s[IDX_W]) begin
      probe_s = {{(32-IDX_W){1'b0}}, pb_sel_s[IDX_W-1:0]};
    end else begin
      probe_s = 32'h8000_0000;
    end
    wr_en_s  = op_valid && ((op_code == OP_TLBWI) || (op_code == OP_TLBWR));
    wr_idx_s = (op_code == OP_TLBWR) ? random : op_index;
    if (random <= wired) begin
      random_nxt_s = MAX_IDX;
    end else begin
      random_nxt_s = random - IDX_W'(1);
    end
  end

  // Entry storage: cleared on reset, written by TLBWI/TLBWR.
  always_ff @(posedge clock) begin
    if (!reset) begin
      present_r <= {ENTRIES{1'b0}};
      g_r  <= {ENTRIES{1'b0}};
      d0_r <= {ENTRIES{1'b0}};
      v0_r <= {ENTRIES{1'b0}};
      d1_r <= {ENTRIES{1'b0}};
      v1_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        vpn2_r[i] <= 19'd0;
        asid_r[i] <= {ASID_W{1'b0}};
        pfn0_r[i] <= 20'd0;
        pfn1_r[i] <= 20'd0;
      end
    end else if (wr_en_s) begin
      present_r[wr_idx_s] <= 1'b1;
      vpn2_r[wr_idx_s]    <= entry_hi[31:13];
      asid_r[wr_idx_s]    <= entry_hi[ASID_W-1:0];
      g_r[wr_idx_s]       <= entry_lo0[0] & entry_lo1[0];
      pfn0_r[wr_idx_s]    <= entry_lo0[25:6];
      d0_r[wr_idx_s]      <= entry_lo0[2];
      v0_r[wr_idx_s]      <= entry_lo0[1];
      pfn1_r[wr_idx_s]    <= entry_lo1[25:6];
      d1_r[wr_idx_s]      <= entry_lo1[2];
      v1_r[wr_idx_s]      <= entry_lo1[1];
    end
  end

  // Registered responses, management results and Random counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_paddr   <= 32'd0;
      rsp_exc     <= 2'd0;
      op_done     <= 1'b0;
      rd_hi       <= 32'd0;
      rd_lo0      <= 32'd0;
      rd_lo1      <= 32'd0;
      probe_index <= 32'd0;
      random      <= MAX_IDX;
    end else begin
      random    <= random_nxt_s;
      rsp_valid <= req_valid;
      op_done   <= op_valid;
      if (req_valid) begin
        rsp_paddr <= lk_paddr_s;
        rsp_exc   <= lk_exc_s;
      end
      if (op_valid) begin
        case (op_code)
          OP_TLBR: begin
            rd_hi  <= {vpn2_r[op_index], {(13-ASID_W){1'b0}}, asid_r[op_index]};
            rd_lo0 <= {6'd0, pfn0_r[op_index], 3'd0, d0_r[op_index], v0_r[op_index], g_r[op_index]};
            rd_lo1 <= {6'd0, pfn1_r[op_index], 3'd0, d1_r[op_index], v1_r[op_index], g_r[op_index]};
          end
          OP_TLBP: probe_index <= probe_s;
          default: begin end
        endcase
      end
    end
  end
endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised, fully-associative MIPS32-style TLB for the CPU's memory stage. It is the configurable successor to the fixed 16-entry translator, adding:

- ASID tagging and global pages.
- A registered lookup response.
- A Random replacement counter with a Wired floor.
- The CP0 management operations TLBWI, TLBWR, TLBR and TLBP.

The block sits between the address generator and the memory arbiter. The CP0 register file drives its management port.

## Interface
Parameters:
- ENTRIES, 16, entry count; power of two, 4..64. IDX_W = log2(ENTRIES) is derived internally.
- ASID_W, 8, ASID width; entry_hi[ASID_W-1:0] carries the ASID.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  lookup request.
- req_vaddr  in  32  virtual address.
- req_write  in  1  store access; selects the dirty check.
- rsp_valid  out  1  lookup result valid; one cycle after req_valid.
- rsp_paddr  out  32  physical address; 0 on exception.
- rsp_exc  out  2  exception code: 0 none, 1 refill (no match), 2 invalid (V=0), 3 modified (store to D=0).
- op_valid  in  1  management op strobe.
- op_code  in  2  management op: 0 TLBWI, 1 TLBWR, 2 TLBR, 3 TLBP.
- op_index  in  IDX_W  Index register.
- wired  in  IDX_W  Wired register.
- entry_hi  in  32  EntryHi: VPN2 [31:13], ASID [ASID_W-1:0]. Also the current ASID for lookups.
- entry_lo0, entry_lo1  in  32 each  EntryLo: PFN [25:6], D [2], V [1], G [0].
- op_done  out  1  one-cycle pulse, cycle after op_valid.
- rd_hi, rd_lo0, rd_lo1  out  32 each  TLBR result.
  - rd_hi: VPN2 and ASID; other bits 0.
  - rd_lo0/rd_lo1: PFN, D and V; G in both equals the entry G bit; other bits 0.
- probe_index  out  32  TLBP result.
  - On hit: bit31=0, index in [IDX_W-1:0].
  - On miss: 0x8000_0000.
- random  out  IDX_W  current Random value.

## Operation
- Entry state:
  - present bit, VPN2[18:0], ASID, G.
  - even half: PFN0, D0, V0.
  - odd half: PFN1, D1, V1.
  - Reset clears all present bits and all fields. A non-present entry never matches.
- Match condition: present AND VPN2 == vaddr[31:13] AND (G OR ASID == entry_hi ASID). If several entries match, the lowest index wins.
- Lookup:
  - vaddr[31:30]==2'b10 (0x8000_0000..0xBFFF_FFFF): unmapped. paddr = vaddr & 0x1FFF_FFFF, exc 0.
  - All other addresses are mapped.
  - No match: exc 1.
  - Match: vaddr[12] selects the odd (1) or even (0) half.
    - V=0: exc 2.
    - Otherwise, req_write=1 and D=0: exc 3.
    - Otherwise: paddr = {PFN, vaddr[11:0]}, exc 0.
- TLBWI: write the entry at op_index.
  - VPN2 and ASID from entry_hi.
  - PFN, D, V from each lo.
  - G = lo0.G & lo1.G.
  - Set present.
- TLBWR: same as TLBWI, but at index = random at that edge.
- TLBR: load rd_* from entry op_index, whether or not it is present.
- TLBP: search using entry_hi with the match rule above; load probe_index.
- Random counter:
  - Resets to ENTRIES-1.
  - Every cycle, if random <= wired then next = ENTRIES-1; else next = random-1.
  - If wired >= ENTRIES-1, random holds at ENTRIES-1.
- Ops and requests are accepted every cycle; there is no backpressure.
- op_valid with an unknown state is illegal. Only one op per cycle by construction.

## Timing
- Reset values of all outputs: rsp_valid=0, rsp_paddr=0, rsp_exc=0, op_done=0, rd_*=0, probe_index=0, random=ENTRIES-1.
- Lookup latency is 1:
  - Inputs are sampled at edge N; rsp_* is registered at edge N and is valid during cycle N+1.
  - rsp_valid=0 on cycles without a request; rsp_paddr and rsp_exc hold their last values.
- Op latency is 1:
  - Writes commit at edge N.
  - rd_*, probe_index and op_done update at edge N.
  - rd_* and probe_index hold until the next TLBR or TLBP respectively.
- Same-edge TLBWI/TLBWR and lookup (or TLBP): the lookup sees the pre-write contents. The write is visible from edge N+1.
- Reset asserted mid-operation: all entries are invalidated and outputs return to reset values at that edge. A pending op is discarded (no op_done).

## Test plan
- Reset, then lookup 0x0040_1000 -> exc 1. Then lookup 0x9FC0_0004 -> paddr 0x1FC0_0004, exc 0.
- TLBWI index 3 with hi=0x0040_0005, lo0 PFN=0x12 D=1 V=1, lo1 V=0. Then:
  - lookup 0x0040_0ABC with ASID 5 -> paddr 0x0001_2ABC, exc 0.
  - 0x0040_1ABC -> exc 2.
  - the same address with ASID 6 -> exc 1.
- Write entry G=1 with D0=0. Load with a different ASID -> hit, exc 0. Store -> exc 3.
- With wired=12, ENTRIES=16: random sequence after reset is 15,14,13,12,15. Issue TLBWR when random=13, then TLBR index 13 -> rd_* equals the written fields.
- TLBP with a matching entry at index 7 -> probe_index 7. Non-matching -> 0x8000_0000. TLBWI and lookup on the same edge -> lookup returns the old result, the next request returns the new one.
- Assert reset between op_valid and op_done -> op_done stays 0 and all entries miss afterwards.
